hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised hazard-detection and forwarding controller for the five-stage pipelined LEGv8 CPU. It keeps a registered shadow of the destination-register state of the EX, MEM and WB stages, and from it generates:
- operand-forwarding selects;
- load-use stalls;
- branch-redirect flushes;
- stall/flush performance counters.

It sits beside the IF_ID/ID_EX/EX_MEM/MEM_WB registers and drives their hold/bubble controls, plus the PC hold. In interlock mode it replaces forwarding with full RAW stalls.

## Interface
Parameters:
- REG_AW, 5, register-address width
- ZERO_REG, 31, register index that is never a hazard source (XZR)
- FWD_EN, 1, 1 = forwarding mode, 0 = interlock mode (no forwarding, stall on every RAW)
- CNT_W, 32, performance-counter width

Ports (clock and reset first):
- clock  in  1  single clock, rising-edge
- reset_n  in  1  asynchronous, active-low reset
- id_valid  in  1  IF_ID holds a real instruction
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID (post Reg2Loc)
- id_rs1_used, id_rs2_used  in  1  source is actually read
- id_rd  in  REG_AW  destination register of the instruction in ID
- id_regwrite, id_memread  in  1  control bits of the instruction in ID
- redirect  in  1  taken branch in MEM (en_jump)
- stall_pc, stall_if_id  out  1  hold PC / IF_ID
- bubble_id_ex  out  1  load zeros into ID_EX control bits
- flush_if_id, flush_id_ex, flush_ex_mem  out  1  clear stage control bits
- fwd_a, fwd_b  out  2  EX operand select: 00 = register file, 01 = EX_MEM ALU_out, 10 = MEM_WB write_data
- id_byp_a, id_byp_b  out  1  ID read-port bypass of MEM_WB write_data
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Shadow entries for the EX, MEM and WB stages each hold: valid, rd, regwrite, memread, rs1, rs2, rs1_used, rs2_used.
  - Only the EX entry's rs fields are consumed.
- A producer p matches source r when all of: p.valid, p.regwrite, p.rd == r, r != ZERO_REG, and the source's used bit is set.
- Forwarding (FWD_EN=1), for each EX source:
  - fwd = 01 if it matches MEM;
  - else fwd = 10 if it matches WB;
  - else fwd = 00.
  - MEM has priority.
- With FWD_EN=0, fwd_a and fwd_b are always 00.
- ID bypass (both modes): id_byp_x = 1 when id_valid and ID source x matches the WB entry.
- Load-use (FWD_EN=1): hazard when id_valid and an ID source matches the EX entry with memread=1.
- Interlock (FWD_EN=0): hazard when id_valid and an ID source matches the EX or MEM entry.
- On a hazard: stall_pc = stall_if_id = bubble_id_ex = 1.
- On redirect: flush_if_id = flush_id_ex = flush_ex_mem = 1, and all stall outputs are 0.
  - Redirect overrides any hazard.
- Shadow update at the rising edge:
  - redirect: EX and MEM become invalid; WB takes the old MEM entry.
  - hazard stall: EX becomes invalid (bubble); MEM takes the old EX entry; WB takes the old MEM entry.
  - normal: EX takes the ID fields with valid = id_valid; MEM takes the old EX entry; WB takes the old MEM entry.
- Counters:
  - stall_cnt increments on every cycle with stall_pc=1.
  - flush_cnt increments on every cycle with redirect=1.
  - Both saturate at 2^CNT_W-1.

## Timing
- All control outputs are combinational from the shadow state and the current ID/redirect inputs; they are valid in the same cycle.
- The shadow is updated at the same edge as the pipeline registers.
- A load-use stall lasts exactly 1 cycle in forwarding mode.
- Interlock stalls last 1–2 cycles, until the producer reaches WB; the read is then covered by id_byp.
- Reset (asynchronous, any cycle, including mid-stall or mid-flush):
  - all shadow valid bits and counters clear immediately;
  - outputs go to stall/flush/bubble = 0, fwd = 00, id_byp = 0, counters = 0.
- After reset_n is released, the first rising edge performs a normal shift.
- Simultaneous redirect and hazard in the same cycle: the flush outputs are asserted, stall_cnt does not increment, and flush_cnt increments.

## Test plan
- ADD X1,X2,X3 then SUB X4,X1,X5 (FWD_EN=1) -> no stall; in SUB's EX cycle fwd_a=01. With one independent instruction between them -> fwd_a=10.
- LDUR X1,[X2,#0] then ADD X3,X1,X4 -> one cycle of stall_pc/stall_if_id/bubble_id_ex=1, then fwd_a=10; stall_cnt goes 0→1.
- ADD X31,X1,X2 then ADD X3,X31,X4 -> no stall, fwd_a=00 (ZERO_REG excluded).
- FWD_EN=0, ADD X1,.. then ADD X2,X1,X1 -> 2 stall cycles, then id_byp_a=id_byp_b=1, fwd=00; stall_cnt=2.
- Taken CBZ with a load-use pair behind it, redirect=1 in the same cycle as the hazard -> all three flushes=1, stalls=0; the next cycle shows EX and MEM invalid (fwd=00); flush_cnt=1.
- Assert reset_n=0 mid-stall -> stall outputs drop to 0 without waiting for a clock edge; counters read 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Purpose: ID-stage instruction fields and redirect in; pipeline hold/flush controls, forward selects and counters out.
// Latency: none (bundle of wires only).
// Backpressure: the stall_* and bubble outputs hold the front of the pipeline; the flush outputs clear it.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    // pipeline -> controller
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              redirect;

    // controller -> pipeline
    logic              stall_pc;
    logic              stall_if_id;
    logic              bubble_id_ex;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              flush_ex_mem;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              id_byp_a;
    logic              id_byp_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_regwrite, id_memread, redirect,
        input  stall_pc, stall_if_id, bubble_id_ex,
               flush_if_id, flush_id_ex, flush_ex_mem,
               fwd_a, fwd_b, id_byp_a, id_byp_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_regwrite, id_memread, redirect,
        output stall_pc, stall_if_id, bubble_id_ex,
               flush_if_id, flush_id_ex, flush_ex_mem,
               fwd_a, fwd_b, id_byp_a, id_byp_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Purpose: LEGv8 5-stage hazard unit: EX/MEM/WB destination shadow, forwarding selects, load-use/RAW stalls, redirect flushes.
// Latency: all controls combinational in the same cycle; the shadow advances on the same edge as the pipeline registers.
// Backpressure: a hazard holds PC and IF_ID and bubbles ID_EX; a redirect flushes the front three stages and overrides any stall.
module hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31,
    parameter bit FWD_EN   = 1'b1,
    parameter int CNT_W    = 32
) (
    input logic        clock,
    input logic        reset_n,
    hazard_ctrl_if.slave bus
);
    localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              rs1_used;
        logic              rs2_used;
    } shadow_t;

    shadow_t ex_q, mem_q, wb_q, id_ent;
    logic    hazard, stall, flush;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // p writes the register that source r actually reads (XZR never counts)
    function automatic logic writes(input shadow_t p, input logic [REG_AW-1:0] r, input logic used);
        return p.valid && p.regwrite && (p.rd == r) && (r != ZERO_IDX) && used;
    endfunction

    // EX operand select: MEM result is newer than WB, so it wins; a bubble in EX never forwards
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] r, input logic used);
        logic [1:0] sel;
        sel = 2'b00;
        if (FWD_EN && ex_q.valid) begin
            if (writes(mem_q, r, used))     sel = 2'b01;
            else if (writes(wb_q, r, used)) sel = 2'b10;
        end
        return sel;
    endfunction

    // Pack the ID instruction into a shadow entry and decide stall/flush for this cycle
    always_comb begin
        id_ent          = '0;
        id_ent.valid    = bus.id_valid;
        id_ent.rd       = bus.id_rd;
        id_ent.regwrite = bus.id_regwrite;
        id_ent.memread  = bus.id_memread;
        id_ent.rs1      = bus.id_rs1;
        id_ent.rs2      = bus.id_rs2;
        id_ent.rs1_used = bus.id_rs1_used;
        id_ent.rs2_used = bus.id_rs2_used;

        hazard = 1'b0;
        if (bus.id_valid) begin
            if (FWD_EN) begin
                // only a load in EX cannot be forwarded in time
                hazard = ex_q.memread &&
                         (writes(ex_q, bus.id_rs1, bus.id_rs1_used) ||
                          writes(ex_q, bus.id_rs2, bus.id_rs2_used));
            end else begin
                // no forwarding: wait until the producer sits in WB (covered by the ID bypass)
                hazard = writes(ex_q,  bus.id_rs1, bus.id_rs1_used) ||
                         writes(ex_q,  bus.id_rs2, bus.id_rs2_used) ||
                         writes(mem_q, bus.id_rs1, bus.id_rs1_used) ||
                         writes(mem_q, bus.id_rs2, bus.id_rs2_used);
            end
        end

        // reset forces every control low even if redirect is still asserted upstream
        flush = reset_n && bus.redirect;
        stall = reset_n && hazard && !bus.redirect;
    end

    assign bus.stall_pc     = stall;
    assign bus.stall_if_id  = stall;
    assign bus.bubble_id_ex = stall;
    assign bus.flush_if_id  = flush;
    assign bus.flush_id_ex  = flush;
    assign bus.flush_ex_mem = flush;
    assign bus.fwd_a        = fwd_sel(ex_q.rs1, ex_q.rs1_used);
    assign bus.fwd_b        = fwd_sel(ex_q.rs2, ex_q.rs2_used);
    assign bus.id_byp_a     = bus.id_valid && writes(wb_q, bus.id_rs1, bus.id_rs1_used);
    assign bus.id_byp_b     = bus.id_valid && writes(wb_q, bus.id_rs2, bus.id_rs2_used);
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;

    // WB source fields and memread are carried only so every stage has the same entry shape
    logic unused_wb;
    assign unused_wb = ^{wb_q.memread, wb_q.rs1, wb_q.rs2, wb_q.rs1_used, wb_q.rs2_used};

    // Shadow shift: redirect kills EX/MEM, a stall inserts a bubble in EX, otherwise ID enters EX
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q <= mem_q;
            if (bus.redirect) begin
                ex_q  <= '0;
                mem_q <= '0;
            end else if (stall) begin
                ex_q  <= '0;
                mem_q <= ex_q;
            end else begin
                ex_q  <= id_ent;
                mem_q <= ex_q;
            end
        end
    end

    // Saturating stall and flush event counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: bench for hazard_ctrl, one forwarding and one interlock instance sharing the same ID stimulus.
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
// Backpressure: stimulus is scripted; in the random phase the reference model follows each stall/flush itself.
module tb_hazard_ctrl;
    localparam int AW = 5;
    localparam int CW = 32;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   tests   = 0;
    int   fails   = 0;

    always #5 clock = ~clock;

    hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bf ();
    hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bi ();

    assign bi.id_valid    = bf.id_valid;
    assign bi.id_rs1      = bf.id_rs1;
    assign bi.id_rs2      = bf.id_rs2;
    assign bi.id_rs1_used = bf.id_rs1_used;
    assign bi.id_rs2_used = bf.id_rs2_used;
    assign bi.id_rd       = bf.id_rd;
    assign bi.id_regwrite = bf.id_regwrite;
    assign bi.id_memread  = bf.id_memread;
    assign bi.redirect    = bf.redirect;

    hazard_ctrl #(.REG_AW(AW), .ZERO_REG(31), .FWD_EN(1'b1), .CNT_W(CW)) dut_f (
        .clock(clock), .reset_n(reset_n), .bus(bf));
    hazard_ctrl #(.REG_AW(AW), .ZERO_REG(31), .FWD_EN(1'b0), .CNT_W(CW)) dut_i (
        .clock(clock), .reset_n(reset_n), .bus(bi));

    // ---------------- reference model: an in-flight instruction list per mode ----------------
    typedef struct {
        bit       valid;
        bit [4:0] rd, rs1, rs2;
        bit       rw, mr, u1, u2;
    } ins_t;

    ins_t        pipe [2][3];   // [mode: 0 interlock, 1 forwarding][stage: 0 EX, 1 MEM, 2 WB]
    int unsigned m_stall [2];
    int unsigned m_flush [2];

    logic [11:0] ctl [2];
    always_comb begin
        ctl[0] = {bi.stall_pc, bi.stall_if_id, bi.bubble_id_ex, bi.flush_if_id, bi.flush_id_ex,
                  bi.flush_ex_mem, bi.fwd_a, bi.fwd_b, bi.id_byp_a, bi.id_byp_b};
        ctl[1] = {bf.stall_pc, bf.stall_if_id, bf.bubble_id_ex, bf.flush_if_id, bf.flush_id_ex,
                  bf.flush_ex_mem, bf.fwd_a, bf.fwd_b, bf.id_byp_a, bf.id_byp_b};
    end

    function automatic ins_t none();
        ins_t n;
        n = '{default: 0};
        return n;
    endfunction

    function automatic ins_t id_ins();
        ins_t c;
        c.valid = bf.id_valid;  c.rd = bf.id_rd;   c.rs1 = bf.id_rs1; c.rs2 = bf.id_rs2;
        c.rw = bf.id_regwrite;  c.mr = bf.id_memread;
        c.u1 = bf.id_rs1_used;  c.u2 = bf.id_rs2_used;
        return c;
    endfunction

    function automatic bit writes(ins_t p, bit [4:0] r, bit used);
        return p.valid && p.rw && (p.rd == r) && (r != 5'd31) && used;
    endfunction

    // stall needed: forwarding only fears a load in EX; interlock fears any writer in EX or MEM
    function automatic bit m_hazard(int m);
        ins_t c;
        int   last;
        c    = id_ins();
        last = (m == 1) ? 0 : 1;
        if (!c.valid) return 1'b0;
        for (int s = 0; s <= last; s++)
            if ((writes(pipe[m][s], c.rs1, c.u1) || writes(pipe[m][s], c.rs2, c.u2)) &&
                (m == 0 || pipe[m][s].mr))
                return 1'b1;
        return 1'b0;
    endfunction

    // youngest writer downstream of EX supplies the operand: 1 = MEM, 2 = WB
    function automatic bit [1:0] m_fwd(int m, bit second);
        ins_t     e;
        bit [4:0] r;
        bit       u;
        e = pipe[m][0];
        r = second ? e.rs2 : e.rs1;
        u = second ? e.u2  : e.u1;
        if (m == 0 || !e.valid) return 2'd0;
        for (int s = 1; s <= 2; s++)
            if (writes(pipe[m][s], r, u)) return 2'(s);
        return 2'd0;
    endfunction

    function automatic logic [11:0] exp_ctl(int m);
        ins_t c;
        bit   st, br, ba, bb;
        c  = id_ins();
        br = bf.redirect;
        st = m_hazard(m) && !br;
        ba = c.valid && writes(pipe[m][2], c.rs1, c.u1);
        bb = c.valid && writes(pipe[m][2], c.rs2, c.u2);
        return {st, st, st, br, br, br, m_fwd(m, 1'b0), m_fwd(m, 1'b1), ba, bb};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int s = 0; s < 3; s++) pipe[m][s] = none();
            m_stall[m] = 0;
            m_flush[m] = 0;
        end
    endtask

    // advance the model as one clock edge would, using the inputs present before the edge
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            bit st;
            st = m_hazard(m) && !bf.redirect;
            if (st && m_stall[m] != 32'hFFFF_FFFF) m_stall[m]++;
            if (bf.redirect && m_flush[m] != 32'hFFFF_FFFF) m_flush[m]++;
            pipe[m][2] = pipe[m][1];
            if (bf.redirect) begin
                pipe[m][1] = none();
                pipe[m][0] = none();
            end else if (st) begin
                pipe[m][1] = pipe[m][0];
                pipe[m][0] = none();
            end else begin
                pipe[m][1] = pipe[m][0];
                pipe[m][0] = id_ins();
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(bit v, int rd, int rs1, int rs2, bit u1, bit u2, bit rw, bit mr, bit br);
        bf.id_valid    = v;        bf.id_rd       = 5'(rd);
        bf.id_rs1      = 5'(rs1);  bf.id_rs2      = 5'(rs2);
        bf.id_rs1_used = u1;       bf.id_rs2_used = u2;
        bf.id_regwrite = rw;       bf.id_memread  = mr;
        bf.redirect    = br;
    endtask

    task automatic nop();
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        nop();
        #1 reset_n = 1'b0;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        // redirect held high while in reset: every control must still read 0
        drive(1'b1, 1, 1, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clock);
        tests++; if (ctl[1] !== 12'd0) begin fails++; $display("FAIL reset_ctl_fwd got %b want 0", ctl[1]); end
        tests++; if (ctl[0] !== 12'd0) begin fails++; $display("FAIL reset_ctl_ilk got %b want 0", ctl[0]); end
        tests++; if (bf.stall_cnt !== 32'd0 || bf.flush_cnt !== 32'd0) begin
            fails++; $display("FAIL reset_cnt got %0d/%0d want 0/0", bf.stall_cnt, bf.flush_cnt); end
        nop();
        @(posedge clock);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_forward();
        apply_reset();
        drive(1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);   // ADD X1,X2,X3
        tick();
        drive(1'b1, 4, 1, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);   // SUB X4,X1,X5
        @(negedge clock);
        tests++; if (bf.stall_pc !== 1'b0) begin fails++; $display("FAIL fwd_no_stall got %b want 0", bf.stall_pc); end
        tick();
        nop();
        @(negedge clock);
        tests++; if (bf.fwd_a !== 2'b01 || bf.fwd_b !== 2'b00) begin
            fails++; $display("FAIL fwd_mem got a=%b b=%b want a=01 b=00", bf.fwd_a, bf.fwd_b); end
        tick();
        drive(1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);   // ADD X1,X2,X3
        tick();
        drive(1'b1, 6, 7, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);   // ADD X6,X7,X8
        tick();
        drive(1'b1, 4, 1, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);   // SUB X4,X1,X5
        tick();
        nop();
        @(negedge clock);
        tests++; if (bf.fwd_a !== 2'b10) begin fails++; $display("FAIL fwd_wb got %b want 10", bf.fwd_a); end
        tick();
    endtask

    task automatic test_load_use();
        apply_reset();
        drive(1'b1, 1, 2, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);   // LDUR X1,[X2,#0]
        tick();
        drive(1'b1, 3, 1, 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);   // ADD X3,X1,X4
        @(negedge clock);
        tests++; if ({bf.stall_pc, bf.stall_if_id, bf.bubble_id_ex} !== 3'b111 || bf.stall_cnt !== 32'd0) begin
            fails++; $display("FAIL ld_use_stall got %b cnt=%0d want 111 cnt=0",
                              {bf.stall_pc, bf.stall_if_id, bf.bubble_id_ex}, bf.stall_cnt); end
        tick();
        @(negedge clock);
        tests++; if (bf.stall_pc !== 1'b0 || bf.stall_cnt !== 32'd1) begin
            fails++; $display("FAIL ld_use_release got stall=%b cnt=%0d want 0 cnt=1", bf.stall_pc, bf.stall_cnt); end
        tick();
        nop();
        @(negedge clock);
        tests++; if (bf.fwd_a !== 2'b10) begin fails++; $display("FAIL ld_use_fwd got %b want 10", bf.fwd_a); end
        tick();
    endtask

    task automatic test_zero_reg();
        apply_reset();
        drive(1'b1, 31, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);  // ADD X31,X1,X2
        tick();
        drive(1'b1, 3, 31, 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);  // ADD X3,X31,X4
        @(negedge clock);
        tests++; if (bf.stall_pc !== 1'b0) begin fails++; $display("FAIL xzr_stall got %b want 0", bf.stall_pc); end
        tick();
        nop();
        @(negedge clock);
        tests++; if (bf.fwd_a !== 2'b00) begin fails++; $display("FAIL xzr_fwd got %b want 00", bf.fwd_a); end
        tick();
    endtask

    task automatic test_interlock();
        apply_reset();
        drive(1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);   // ADD X1,X2,X3
        tick();
        drive(1'b1, 2, 1, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);   // ADD X2,X1,X1
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            tests++; if (bi.stall_pc !== 1'b1) begin fails++; $display("FAIL ilk_stall%0d got %b want 1", k, bi.stall_pc); end
            tick();
        end
        @(negedge clock);
        tests++; if (bi.stall_pc !== 1'b0 || bi.id_byp_a !== 1'b1 || bi.id_byp_b !== 1'b1 || bi.stall_cnt !== 32'd2) begin
            fails++; $display("FAIL ilk_bypass got stall=%b byp=%b%b cnt=%0d want 0 11 2",
                              bi.stall_pc, bi.id_byp_a, bi.id_byp_b, bi.stall_cnt); end
        tick();
        nop();
        @(negedge clock);
        tests++; if (bi.fwd_a !== 2'b00 || bi.fwd_b !== 2'b00) begin
            fails++; $display("FAIL ilk_fwd got %b %b want 00 00", bi.fwd_a, bi.fwd_b); end
        tick();
    endtask

    task automatic test_redirect();
        apply_reset();
        drive(1'b1, 0, 5, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // CBZ X5
        tick();
        drive(1'b1, 1, 2, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);   // LDUR X1,[X2,#0]
        tick();
        drive(1'b1, 3, 1, 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);   // ADD X3,X1,X4 with CBZ taken in MEM
        @(negedge clock);
        tests++; if (ctl[1][11:6] !== 6'b000111) begin
            fails++; $display("FAIL redir_ctl got %b want 000111", ctl[1][11:6]); end
        tick();
        nop();
        @(negedge clock);
        tests++; if (bf.fwd_a !== 2'b00 || bf.fwd_b !== 2'b00 || bf.flush_cnt !== 32'd1 || bf.stall_cnt !== 32'd0) begin
            fails++; $display("FAIL redir_after got fwd=%b%b flush_cnt=%0d stall_cnt=%0d want 0000 1 0",
                              bf.fwd_a, bf.fwd_b, bf.flush_cnt, bf.stall_cnt); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        drive(1'b1, 1, 2, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);   // LDUR X1
        tick();
        drive(1'b1, 3, 1, 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);   // ADD X3,X1,X4 (stalls once)
        tick();
        tick();
        drive(1'b1, 5, 2, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);   // LDUR X5
        tick();
        drive(1'b1, 6, 5, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);   // ADD X6,X5
        @(negedge clock);
        tests++; if (bf.stall_pc !== 1'b1 || bf.stall_cnt !== 32'd1) begin
            fails++; $display("FAIL midrst_pre got stall=%b cnt=%0d want 1 1", bf.stall_pc, bf.stall_cnt); end
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        tests++; if ({bf.stall_pc, bf.stall_if_id, bf.bubble_id_ex} !== 3'b000 || bf.stall_cnt !== 32'd0 || bf.flush_cnt !== 32'd0) begin
            fails++; $display("FAIL midrst_async got %b cnt=%0d/%0d want 000 0/0",
                              {bf.stall_pc, bf.stall_if_id, bf.bubble_id_ex}, bf.stall_cnt, bf.flush_cnt); end
        nop();
        @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            int r1, r2, rdv;
            r1  = $urandom_range(0, 4); if (r1 == 4) r1 = 31;
            r2  = $urandom_range(0, 4); if (r2 == 4) r2 = 31;
            rdv = $urandom_range(0, 4); if (rdv == 4) rdv = 31;
            drive(($urandom_range(0, 3) != 0), rdv, r1, r2,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0));
            @(negedge clock);
            for (int m = 0; m < 2; m++) begin
                logic [11:0] want;
                want = exp_ctl(m);
                tests++; if (ctl[m] !== want) begin
                    fails++; $display("FAIL rand_ctl mode%0d cyc%0d got %b want %b", m, n, ctl[m], want); end
            end
            tests++; if (bf.stall_cnt !== m_stall[1] || bf.flush_cnt !== m_flush[1]) begin
                fails++; $display("FAIL rand_cnt_fwd cyc%0d got %0d/%0d want %0d/%0d",
                                  n, bf.stall_cnt, bf.flush_cnt, m_stall[1], m_flush[1]); end
            tests++; if (bi.stall_cnt !== m_stall[0] || bi.flush_cnt !== m_flush[0]) begin
                fails++; $display("FAIL rand_cnt_ilk cyc%0d got %0d/%0d want %0d/%0d",
                                  n, bi.stall_cnt, bi.flush_cnt, m_stall[0], m_flush[0]); end
            tick();
        end
    endtask

    initial begin
        model_reset();
        nop();
        test_reset();
        test_forward();
        test_load_use();
        test_zero_reg();
        test_interlock();
        test_redirect();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
